// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - LoongArch execute stage: ALU, data SRAM request FSM, forwarding to ID.
// Optional misaligned ld.w/st.w detection is enabled by defining EX_ALIGN_CHECK_EN.
module ex_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ID_to_EX_valid,
    input  logic [149:0] to_EX_data,
    output logic         EX_allow_in,
    input  logic         MEM_allow_in,
    output logic         EX_to_MEM_valid,
`ifdef EX_ALIGN_CHECK_EN
    output logic [71:0]  to_MEM_data,
`else
    output logic [70:0]  to_MEM_data,
`endif
    output logic [37:0]  EX_forward,
    output logic         data_sram_req,
    output logic         data_sram_wr,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic [3:0]   data_sram_wstrb,
    input  logic         data_sram_addr_ok
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ISSUED = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic         ex_valid;
    logic [149:0] bundle;
    logic         ex_ready_go;

    logic [31:0]  pc;
    logic [31:0]  rj_value;
    logic [31:0]  rkd_value;
    logic [31:0]  imm;
    logic [11:0]  alu_op;
    logic         src1_is_pc;
    logic         src2_is_imm;
    logic         mem_we;
    logic         res_from_mem;
    logic [4:0]   dest;
    logic         gr_we;

    logic [31:0]  src1;
    logic [31:0]  src2;
    logic [31:0]  alu_result;
    logic [4:0]   shamt;
    logic         mem_op;
    logic         ale;

    assign {pc, rj_value, rkd_value, imm, alu_op, src1_is_pc, src2_is_imm,
            mem_we, res_from_mem, dest, gr_we} = bundle;

    // Pipeline valid and bundle registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid <= 1'b0;
            bundle   <= '0;
        end else begin
            if (EX_allow_in) begin
                ex_valid <= ID_to_EX_valid;
            end
            if (ID_to_EX_valid && EX_allow_in) begin
                bundle <= to_EX_data;
            end
        end
    end

    assign src1  = src1_is_pc  ? pc  : rj_value;
    assign src2  = src2_is_imm ? imm : rkd_value;
    assign shamt = src2[4:0];

    // AND-OR mux over the one-hot opcode, so an empty opcode yields zero
    always_comb begin
        alu_result = 32'd0;
        if (alu_op[0])  alu_result = alu_result | (src1 + src2);
        if (alu_op[1])  alu_result = alu_result | (src1 - src2);
        if (alu_op[2])  alu_result = alu_result | {31'd0, $signed(src1) < $signed(src2)};
        if (alu_op[3])  alu_result = alu_result | {31'd0, src1 < src2};
        if (alu_op[4])  alu_result = alu_result | (src1 & src2);
        if (alu_op[5])  alu_result = alu_result | ~(src1 | src2);
        if (alu_op[6])  alu_result = alu_result | (src1 | src2);
        if (alu_op[7])  alu_result = alu_result | (src1 ^ src2);
        if (alu_op[8])  alu_result = alu_result | (src1 << shamt);
        if (alu_op[9])  alu_result = alu_result | (src1 >> shamt);
        if (alu_op[10]) alu_result = alu_result | 32'($signed(src1) >>> shamt);
        if (alu_op[11]) alu_result = alu_result | src2;
    end

    assign mem_op = mem_we | res_from_mem;

`ifdef EX_ALIGN_CHECK_EN
    assign ale = ex_valid & mem_op & (alu_result[1:0] != 2'b00);
`else
    assign ale = 1'b0;
`endif

    // Request FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (data_sram_req) begin
                    if (!data_sram_addr_ok) begin
                        state_next = REQ;
                    end else if (!MEM_allow_in) begin
                        state_next = ISSUED;
                    end
                end
            end
            REQ: begin
                if (data_sram_addr_ok) begin
                    state_next = MEM_allow_in ? IDLE : ISSUED;
                end
            end
            ISSUED: begin
                if (MEM_allow_in) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request FSM: outputs; REQ keeps req high until accepted, ISSUED never re-requests
    always_comb begin
        data_sram_req = 1'b0;
        case (state)
            IDLE:    data_sram_req = ex_valid & mem_op & ~ale;
            REQ:     data_sram_req = 1'b1;
            ISSUED:  data_sram_req = 1'b0;
            default: data_sram_req = 1'b0;
        endcase
    end

    assign ex_ready_go = ~mem_op
                       | (data_sram_req & data_sram_addr_ok)
                       | (state == ISSUED)
                       | ale;

    assign EX_allow_in     = ~ex_valid | (ex_ready_go & MEM_allow_in);
    assign EX_to_MEM_valid = ex_valid & ex_ready_go;

    assign data_sram_wr    = ex_valid & mem_we;
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rkd_value;
    assign data_sram_wstrb = {4{ex_valid & mem_we}};

`ifdef EX_ALIGN_CHECK_EN
    assign to_MEM_data = {pc, alu_result, res_from_mem, dest, gr_we, ale};
`else
    assign to_MEM_data = {pc, alu_result, res_from_mem, dest, gr_we};
`endif

    // A bubble must not look like a producer to ID's hazard logic
    assign EX_forward = ex_valid ? {dest, alu_result, res_from_mem} : 38'd0;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - table-driven and sequence checks for ex_stage.
module tb_ex_stage;

`ifdef EX_ALIGN_CHECK_EN
    localparam int MW  = 72;
    localparam int OFF = 1;
`else
    localparam int MW  = 71;
    localparam int OFF = 0;
`endif

    logic          clk;
    logic          reset;
    logic          ID_to_EX_valid;
    logic [149:0]  to_EX_data;
    logic          EX_allow_in;
    logic          MEM_allow_in;
    logic          EX_to_MEM_valid;
    logic [MW-1:0] to_MEM_data;
    logic [37:0]   EX_forward;
    logic          data_sram_req;
    logic          data_sram_wr;
    logic [31:0]   data_sram_addr;
    logic [31:0]   data_sram_wdata;
    logic [3:0]    data_sram_wstrb;
    logic          data_sram_addr_ok;

    int total;
    int bad;
    int hs_count;

    ex_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ID_to_EX_valid    (ID_to_EX_valid),
        .to_EX_data        (to_EX_data),
        .EX_allow_in       (EX_allow_in),
        .MEM_allow_in      (MEM_allow_in),
        .EX_to_MEM_valid   (EX_to_MEM_valid),
        .to_MEM_data       (to_MEM_data),
        .EX_forward        (EX_forward),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr_ok (data_sram_addr_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && data_sram_req && data_sram_addr_ok) hs_count <= hs_count + 1;
    end

    typedef struct {
        string        name;
        logic [149:0] bundle;
        logic [4:0]   dest;
        logic [31:0]  exp;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [149:0] mk(input logic [31:0] pc, input logic [31:0] rj,
                                        input logic [31:0] rkd, input logic [31:0] imm,
                                        input int op, input logic s1pc, input logic s2imm,
                                        input logic we, input logic rfm,
                                        input logic [4:0] dest, input logic gw);
        logic [11:0] oh;
        oh = (op < 0) ? 12'd0 : (12'd1 << op);
        return {pc, rj, rkd, imm, oh, s1pc, s2imm, we, rfm, dest, gw};
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ID_to_EX_valid    = 1'b0;
        MEM_allow_in      = 1'b1;
        data_sram_addr_ok = 1'b0;
    endtask

    logic [31:0] res;

    initial begin
        total = 0;
        bad = 0;
        hs_count = 0;
        reset = 1'b1;
        to_EX_data = '0;
        idle_inputs();

        vecs[0]  = '{"add_ovf", mk(0, 32'h7fffffff, 1, 0, 0, 0, 0, 0, 0, 5'd1, 1), 5'd1, 32'h80000000};
        vecs[1]  = '{"sub",     mk(0, 5, 7, 0, 1, 0, 0, 0, 0, 5'd2, 1), 5'd2, 32'hfffffffe};
        vecs[2]  = '{"slt",     mk(0, 32'hffffffff, 1, 0, 2, 0, 0, 0, 0, 5'd3, 1), 5'd3, 32'h1};
        vecs[3]  = '{"sltu",    mk(0, 32'hffffffff, 1, 0, 3, 0, 0, 0, 0, 5'd4, 1), 5'd4, 32'h0};
        vecs[4]  = '{"and",     mk(0, 32'h0000f0f0, 32'h0000ff00, 0, 4, 0, 0, 0, 0, 5'd5, 1), 5'd5, 32'h0000f000};
        vecs[5]  = '{"nor",     mk(0, 32'h0f0f0000, 32'h000000f0, 0, 5, 0, 0, 0, 0, 5'd6, 1), 5'd6, 32'hf0f0ff0f};
        vecs[6]  = '{"or",      mk(0, 32'h12000000, 32'h00000034, 0, 6, 0, 0, 0, 0, 5'd7, 1), 5'd7, 32'h12000034};
        vecs[7]  = '{"xor",     mk(0, 32'hffff0000, 32'h0ff00ff0, 0, 7, 0, 0, 0, 0, 5'd8, 1), 5'd8, 32'hf00f0ff0};
        vecs[8]  = '{"sll31",   mk(0, 1, 31, 0, 8, 0, 0, 0, 0, 5'd9, 1), 5'd9, 32'h80000000};
        vecs[9]  = '{"sll33",   mk(0, 3, 33, 0, 8, 0, 0, 0, 0, 5'd10, 1), 5'd10, 32'h00000006};
        vecs[10] = '{"srl",     mk(0, 32'h80000000, 4, 0, 9, 0, 0, 0, 0, 5'd11, 1), 5'd11, 32'h08000000};
        vecs[11] = '{"sra",     mk(0, 32'h80000000, 0, 4, 10, 0, 1, 0, 0, 5'd12, 1), 5'd12, 32'hf8000000};
        vecs[12] = '{"lui",     mk(0, 32'h55555555, 0, 32'h12345000, 11, 0, 1, 0, 0, 5'd13, 1), 5'd13, 32'h12345000};
        vecs[13] = '{"pcadd",   mk(32'h1c000000, 32'h99, 0, 4, 0, 1, 1, 0, 0, 5'd14, 1), 5'd14, 32'h1c000004};
        vecs[14] = '{"noop",    mk(0, 32'h1234, 32'h5678, 0, -1, 0, 0, 0, 0, 5'd15, 1), 5'd15, 32'h0};

        #2;
        check("rst_allow_in", 72'(EX_allow_in), 72'd1);
        check("rst_to_mem_valid", 72'(EX_to_MEM_valid), 72'd0);
        check("rst_req", 72'(data_sram_req), 72'd0);
        check("rst_forward", 72'(EX_forward), 72'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // single ALU operations
        foreach (vecs[i]) begin
            @(negedge clk);
            ID_to_EX_valid = 1'b1;
            to_EX_data     = vecs[i].bundle;
            @(negedge clk);
            ID_to_EX_valid = 1'b0;
            check({vecs[i].name, "_valid"}, 72'(EX_to_MEM_valid), 72'd1);
            check({vecs[i].name, "_fwd"}, 72'(EX_forward), 72'({vecs[i].dest, vecs[i].exp, 1'b0}));
            res = to_MEM_data[OFF+38 -: 32];
            check({vecs[i].name, "_mem_res"}, 72'(res), 72'(vecs[i].exp));
            check({vecs[i].name, "_req"}, 72'(data_sram_req), 72'd0);
        end
        @(negedge clk);
        check("bubble_fwd", 72'(EX_forward), 72'd0);
        check("bubble_valid", 72'(EX_to_MEM_valid), 72'd0);

        // st.w with addr_ok held low three cycles
        ID_to_EX_valid = 1'b1;
        to_EX_data = mk(0, 32'h1000, 32'hdeadbeef, 8, 0, 0, 1, 1, 0, 5'd0, 0);
        @(negedge clk);
        ID_to_EX_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("st_req", 72'(data_sram_req), 72'd1);
            check("st_addr", 72'(data_sram_addr), 72'h1008);
            check("st_wdata", 72'(data_sram_wdata), 72'hdeadbeef);
            check("st_wstrb", 72'(data_sram_wstrb), 72'hf);
            check("st_wr", 72'(data_sram_wr), 72'd1);
            check("st_wait_valid", 72'(EX_to_MEM_valid), 72'd0);
            check("st_wait_allow", 72'(EX_allow_in), 72'd0);
            if (c < 2) @(negedge clk);
        end
        data_sram_addr_ok = 1'b1;
        #1;
        check("st_ok_valid", 72'(EX_to_MEM_valid), 72'd1);
        check("st_ok_allow", 72'(EX_allow_in), 72'd1);
        @(negedge clk);
        data_sram_addr_ok = 1'b0;
        check("st_after_req", 72'(data_sram_req), 72'd0);
        check("st_after_valid", 72'(EX_to_MEM_valid), 72'd0);
        check("st_handshakes", 72'(hs_count), 72'd1);

        // ld.w accepted while MEM is stalled
        hs_count = 0;
        MEM_allow_in = 1'b0;
        data_sram_addr_ok = 1'b1;
        ID_to_EX_valid = 1'b1;
        to_EX_data = mk(0, 32'h2000, 0, 32'h10, 0, 0, 1, 0, 1, 5'd5, 1);
        @(negedge clk);
        ID_to_EX_valid = 1'b0;
        check("ld_req", 72'(data_sram_req), 72'd1);
        check("ld_addr", 72'(data_sram_addr), 72'h2010);
        check("ld_fwd", 72'(EX_forward), 72'({5'd5, 32'h2010, 1'b1}));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("ld_issued_req", 72'(data_sram_req), 72'd0);
            check("ld_issued_valid", 72'(EX_to_MEM_valid), 72'd1);
            check("ld_issued_allow", 72'(EX_allow_in), 72'd0);
            check("ld_issued_load", 72'(EX_forward[0]), 72'd1);
        end
        data_sram_addr_ok = 1'b0;
        MEM_allow_in = 1'b1;
        #1;
        check("ld_release_allow", 72'(EX_allow_in), 72'd1);
        @(negedge clk);
        check("ld_done_valid", 72'(EX_to_MEM_valid), 72'd0);
        check("ld_handshakes", 72'(hs_count), 72'd1);

        // back-to-back add.w stream
        ID_to_EX_valid = 1'b1;
        to_EX_data = mk(0, 100, 0, 0, 0, 0, 1, 0, 0, 5'd1, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stream_allow", 72'(EX_allow_in), 72'd1);
            check("stream_valid", 72'(EX_to_MEM_valid), 72'd1);
            check("stream_res", 72'(EX_forward[32:1]), 72'(100 + i));
            if (i < 3) to_EX_data = mk(0, 100, 0, 32'(i + 1), 0, 0, 1, 0, 0, 5'(i + 2), 1);
            else ID_to_EX_valid = 1'b0;
        end
        @(negedge clk);

        // reset while a store is waiting in REQ
        ID_to_EX_valid = 1'b1;
        to_EX_data = mk(0, 32'h3000, 32'h1, 0, 0, 0, 1, 1, 0, 5'd0, 0);
        @(negedge clk);
        ID_to_EX_valid = 1'b0;
        @(negedge clk);
        check("rq_pre_req", 72'(data_sram_req), 72'd1);
        reset = 1'b1;
        #1;
        check("rq_req", 72'(data_sram_req), 72'd0);
        check("rq_valid", 72'(EX_to_MEM_valid), 72'd0);
        check("rq_fwd", 72'(EX_forward), 72'd0);
        check("rq_allow", 72'(EX_allow_in), 72'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rq_after_req", 72'(data_sram_req), 72'd0);

`ifdef EX_ALIGN_CHECK_EN
        // misaligned ld.w is flagged instead of issued
        hs_count = 0;
        ID_to_EX_valid = 1'b1;
        to_EX_data = mk(0, 32'h1000, 0, 2, 0, 0, 1, 0, 1, 5'd3, 1);
        @(negedge clk);
        ID_to_EX_valid = 1'b0;
        check("ale_req", 72'(data_sram_req), 72'd0);
        check("ale_valid", 72'(EX_to_MEM_valid), 72'd1);
        check("ale_bit", 72'(to_MEM_data[0]), 72'd1);
        @(negedge clk);
        check("ale_done", 72'(EX_to_MEM_valid), 72'd0);
        check("ale_handshakes", 72'(hs_count), 72'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
